// File: rtl/softmax_norm.sv
// softmax_norm: divides each buffered exp value (Q2.6) by its row sum, emitting Q0.8 probabilities.
// Build option SOFTMAX_ROUND_EN: round-to-nearest quotients; default build truncates.
module softmax_norm #(
    parameter int DW      = 8,
    parameter int ROW_LEN = 8,
    parameter int SUM_W   = DW + $clog2(ROW_LEN),
    parameter int QW      = 9,
    parameter int OCRED   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_credit,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    input  logic          out_credit,
    output logic          err
);
    localparam int IW  = $clog2(ROW_LEN);
    localparam int CW  = $clog2(QW);
    localparam int OW  = $clog2(OCRED + 1);
    localparam int DDW = DW + 9;
    localparam logic [1:0] IDLE = 2'd0, DIV = 2'd1, EMIT = 2'd2;

    logic [DW-1:0]    mem [ROW_LEN];
    logic [ROW_LEN-1:0] full;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic [SUM_W-1:0] sum_acc, sum_div, rem, cur_rem, nxt_rem;
    logic             row_rdy;
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [QW-1:0]    dq, cur_dq;
    logic [OW-1:0]    ocnt;
    logic [DDW-1:0]   dividend;
    logic [SUM_W:0]   trial;
    logic             wr_ok, wr_end, fire, last, take, inc, ge;

    // handshake decode, one restoring-divider step, and emit-cycle outputs
    always_comb begin
        wr_ok     = in_valid && !full[wr_idx];
        wr_end    = wr_ok && (wr_idx == IW'(ROW_LEN - 1));
        fire      = (state == EMIT) && (ocnt != '0);
        last      = rd_idx == IW'(ROW_LEN - 1);
        take      = row_rdy && ((state == IDLE) || (fire && last));
        inc       = out_credit && (fire || ocnt != OW'(OCRED));
`ifdef SOFTMAX_ROUND_EN
        dividend  = DDW'({mem[rd_idx], 8'd0}) + DDW'(sum_div >> 1);
`else
        dividend  = DDW'({mem[rd_idx], 8'd0});
`endif
        cur_rem   = (cnt == '0) ? SUM_W'(dividend >> QW) : rem;
        cur_dq    = (cnt == '0) ? dividend[QW-1:0] : dq;
        trial     = {cur_rem, cur_dq[QW-1]};
        ge        = trial >= {1'b0, sum_div};
        nxt_rem   = SUM_W'(ge ? trial - {1'b0, sum_div} : trial);
        in_credit = fire;
        out_valid = fire;
        out_last  = fire && last;
        out_data  = (!fire || sum_div == '0) ? 8'd0 : (dq > QW'(255) ? 8'hFF : dq[7:0]);
    end

    // row buffer storage; occupancy is tracked separately so no reset is needed here
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= in_data;
    end

    // input side: slot occupancy, running row sum, row-complete flag, credit-violation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            sum_acc <= '0;
            sum_div <= '0;
            row_rdy <= 1'b0;
            full    <= '0;
            err     <= 1'b0;
        end else begin
            full    <= (full | (ROW_LEN'(wr_ok) << wr_idx)) & ~(ROW_LEN'(fire) << rd_idx);
            err     <= err | (in_valid && !wr_ok);
            row_rdy <= wr_end | (row_rdy & !take);
            if (wr_ok) begin
                wr_idx  <= wr_idx + IW'(1);
                sum_acc <= wr_end ? '0 : sum_acc + SUM_W'(in_data);
                if (wr_end) sum_div <= sum_acc + SUM_W'(in_data);
            end
        end
    end

    // divide/emit sequencer and downstream credit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            dq     <= '0;
            rd_idx <= '0;
            ocnt   <= OW'(OCRED);
        end else begin
            ocnt <= ocnt + OW'(inc) - OW'(fire);
            if (state == IDLE) begin
                if (row_rdy) begin
                    state  <= DIV;
                    rd_idx <= '0;
                    cnt    <= '0;
                end
            end else if (state == DIV) begin
                rem   <= nxt_rem;
                dq    <= {cur_dq[QW-2:0], ge};
                cnt   <= (cnt == CW'(QW - 1)) ? '0 : cnt + CW'(1);
                if (cnt == CW'(QW - 1)) state <= EMIT;
            end else if (fire) begin
                cnt    <= '0;
                rd_idx <= last ? '0 : rd_idx + IW'(1);
                state  <= (!last || row_rdy) ? DIV : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: directed rows checked by a scoreboard queue drained by an output monitor
`timescale 1ns/1ps
module tb_softmax_norm;
    localparam int ROW_LEN = 8;
    typedef logic [7:0] row_t [ROW_LEN];

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0] in_data = 8'd0, out_data;
    logic in_credit, out_valid, out_last, err, out_credit;
    logic auto_cr = 1'b0, a_cr = 1'b0, m_cr = 1'b0, prev_v = 1'b0;
    logic [8:0] exp_q [$];
    int n_vec = 0, n_bad = 0, out_cnt = 0, cr_cnt = 0, sent = 0, cr_base = 0;
    row_t d, e;

    assign out_credit = auto_cr ? a_cr : m_cr;

    softmax_norm dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_credit(in_credit),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_credit(out_credit), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] v);
        int t = 0;
        while (ROW_LEN - sent + cr_cnt - cr_base <= 0 && t < 400) begin
            tick(1);
            t++;
        end
        check("upstream_credit_wait", t < 400, 1);
        in_valid = 1'b1;
        in_data  = v;
        tick(1);
        in_valid = 1'b0;
        sent++;
    endtask

    task automatic row(input row_t rv, input row_t ev);
        for (int i = 0; i < ROW_LEN; i++) exp_q.push_back({i == ROW_LEN - 1, ev[i]});
        for (int i = 0; i < ROW_LEN; i++) send(rv[i]);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            tick(1);
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        tick(3);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_in_credit"}, in_credit, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [8:0] x;
        forever begin
            @(negedge clk);
            if (in_credit) cr_cnt++;
            if (out_valid) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0h with nothing expected", {out_last, out_data});
                end else begin
                    x = exp_q.pop_front();
                    check("output_last_data", {out_last, out_data}, x);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            a_cr   = prev_v;
            prev_v = out_valid;
        end
    end

    initial begin
        int b;
        tick(2);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(2);
        auto_cr = 1'b1;

        b = cr_cnt;
        d = '{default: 8'h40};
        e = '{default: 8'h20};
        row(d, e);
        drain();
        check("row1_in_credits", cr_cnt - b, 8);

        d = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        e = d;
        row(d, e);
        drain();

        d = '{8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef SOFTMAX_ROUND_EN
        e = '{8'h55, 8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        e = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        row(d, e);
        drain();

        auto_cr = 1'b0;
        m_cr = 1'b1;
        tick(1);
        m_cr = 1'b0;
        b = out_cnt;
        d = '{default: 8'h40};
        e = '{default: 8'h20};
        row(d, e);
        tick(60);
        check("stall_after_two", out_cnt - b, 2);
        m_cr = 1'b1;
        tick(1);
        m_cr = 1'b0;
        check("emit_cycle_after_credit", out_valid, 1);
        tick(20);
        check("stall_after_three", out_cnt - b, 3);
        m_cr = 1'b1;
        tick(1);
        check("emit_with_credit", out_valid, 1);
        tick(1);
        m_cr = 1'b0;
        tick(15);
        check("fifth_from_kept_credit", out_cnt - b, 5);
        tick(20);
        check("stall_after_five", out_cnt - b, 5);
        m_cr = 1'b1;
        tick(1);
        m_cr = 1'b0;
        tick(1);
        auto_cr = 1'b1;
        drain();
        check("window_row_count", out_cnt - b, 8);
        auto_cr = 1'b0;
        m_cr = 1'b1;
        tick(1);
        m_cr = 1'b0;
        auto_cr = 1'b1;

        b = cr_cnt;
        d = '{8'h80, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        e = d;
        row(d, e);
        d = '{default: 8'h00};
        e = d;
        row(d, e);
        d = '{default: 8'h40};
        e = '{default: 8'h20};
        row(d, e);
        drain();
        check("b2b_no_err", err, 0);
        check("b2b_in_credits", cr_cnt - b, 24);

        row(d, e);
        in_valid = 1'b1;
        in_data  = 8'hC0;
        tick(1);
        in_valid = 1'b0;
        check("overflow_err_set", err, 1);
        drain();
        check("overflow_err_sticky", err, 1);

        b = out_cnt;
        for (int i = 0; i < ROW_LEN; i++) send(8'h40);
        tick(5);
        rst = 1'b1;
        tick(1);
        check_idle_outputs("mid_div_reset");
        rst = 1'b0;
        sent = 0;
        cr_base = cr_cnt;
        tick(40);
        check("no_output_after_reset", out_cnt - b, 0);

        d = '{8'h80, 8'h20, 8'h20, 8'h10, 8'h10, 8'h08, 8'h08, 8'h10};
        e = d;
        row(d, e);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
